// File: rtl/bist_controller16.sv
// bist_controller16: LFSR pattern sequencer for a 16-bit MISR; holds the analyzer in reset until
// the first response arrives, then captures and checks the signature after the last one.
module bist_controller16 #(
    parameter int CNT_W   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [15:0]      seed,
    input  logic [15:0]      golden,
    input  logic             abort,
    output logic [15:0]      pat_out,
    output logic             pat_valid,
    output logic             sa_reset_b,
    input  logic [15:0]      sa_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, CAPTURE} state_t;
    localparam logic [3:0] LAT4  = 4'(LATENCY);
    localparam logic [2:0] DLAST = 3'(LATENCY - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d;
    logic [2:0] dcnt_q, dcnt_d;
    logic [3:0] lat_q, lat_d;
    logic [15:0] lfsr_q, lfsr_d, golden_q, golden_d;
    logic [15:0] pat_out_q, pat_out_d, signature_q, signature_d;
    logic pat_valid_q, pat_valid_d, sa_reset_b_q, sa_reset_b_d;
    logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic last_pat, seq;
    assign last_pat = cnt_q == n_q - 1'b1;
    assign seq = state_q == RUN || state_q == DRAIN;
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        lfsr_d      = lfsr_q;
        golden_d    = golden_q;
        signature_d = signature_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d     = INIT;
                n_d         = pattern_count;
                lfsr_d      = (seed == 16'h0000) ? 16'h0001 : seed;
                golden_d    = golden;
                signature_d = '0;
                pass_d      = 1'b0;
            end
            INIT: begin
                state_d = (n_q == '0) ? CAPTURE : RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d  = cnt_q + 1'b1;
                dcnt_d = '0;
                lfsr_d = {lfsr_q[14:0], 1'b0} ^ (lfsr_q[15] ? 16'h100B : 16'h0000);
                if (last_pat) state_d = (LATENCY == 0) ? CAPTURE : DRAIN;
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DLAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                signature_d = sa_out;
                pass_d      = sa_out == golden_q;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            signature_d = signature_q;
            pass_d      = pass_q;
        end
        // lat counts RUN/DRAIN cycles, saturating at LATENCY: the analyzer is released once it is reached
        lat_d        = seq ? lat_q + {3'b000, lat_q < LAT4} : '0;
        pat_valid_d  = state_d == RUN;
        pat_out_d    = pat_valid_d ? lfsr_d : '0;
        sa_reset_b_d = (state_d == RUN || state_d == DRAIN) && lat_d >= LAT4;
        busy_d       = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= IDLE;
            n_q          <= '0;
            cnt_q        <= '0;
            dcnt_q       <= '0;
            lat_q        <= '0;
            lfsr_q       <= '0;
            golden_q     <= '0;
            pat_out_q    <= '0;
            signature_q  <= '0;
            pat_valid_q  <= 1'b0;
            sa_reset_b_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            dcnt_q       <= dcnt_d;
            lat_q        <= lat_d;
            lfsr_q       <= lfsr_d;
            golden_q     <= golden_d;
            pat_out_q    <= pat_out_d;
            signature_q  <= signature_d;
            pat_valid_q  <= pat_valid_d;
            sa_reset_b_q <= sa_reset_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end
    assign pat_out    = pat_out_q;
    assign pat_valid  = pat_valid_q;
    assign sa_reset_b = sa_reset_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = signature_q;
endmodule

// File: doc/bist_controller16.md
# bist_controller16

Built-in self-test sequencer for the 16-bit signature analyzer (MISR) datapath. It generates LFSR test patterns for a block under test and holds the analyzer in its set state until the first response arrives. It then captures the compacted signature at the exact cycle the last response has been absorbed and compares it with a golden value. It sits between the test-access logic (start/golden/pass) and one `signature_analyzer16` instance, whose `reset_b` it drives.

## Interface
- `CNT_W`, 16: width of the pattern-count input and internal pattern counter.
- `LATENCY`, 2: cycles from `pat_out` to the matching response at the analyzer `in` port. Legal range is 0..7.

- `clk`  in  1  Single clock. It also clocks the analyzer.
- `reset_b`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Run request. Sampled only in IDLE.
- `pattern_count`  in  CNT_W  Number of patterns N. Sampled with `start`.
- `seed`  in  16  LFSR seed. Sampled with `start`. A seed of 0 is replaced by 16'h0001.
- `golden`  in  16  Expected signature. Sampled with `start`.
- `abort`  in  1  Synchronous cancel of the current run.
- `pat_out`  out  16  Test pattern driven to the block under test.
- `pat_valid`  out  1  High during the RUN cycles only.
- `sa_reset_b`  out  1  Registered, glitch-free drive to the analyzer `reset_b`. While low, the analyzer holds 16'hFFFF.
- `sa_out`  in  16  Analyzer `out`.
- `busy`  out  1  High from INIT through CAPTURE.
- `done`  out  1  One-cycle completion pulse.
- `pass`  out  1  Comparison result, held until the next accepted `start`.
- `signature`  out  16  Captured signature, held until the next accepted `start`.

## Operation
- Reset values:
  - `pat_out`=0, `pat_valid`=0, `sa_reset_b`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0.
  - State is IDLE.
- States are IDLE → INIT → RUN → DRAIN → CAPTURE → IDLE.
- IDLE:
  - `sa_reset_b`=0.
  - On `start` with `abort` low: latch N, seed and golden; clear `pass` and `signature`; go to INIT.
- INIT: one cycle. `sa_reset_b`=0 and the LFSR is loaded with the seed.
- RUN: N cycles, k=0..N-1.
  - `pat_valid`=1 and `pat_out`=P_k.
  - P_0 is the seed.
  - P_{k+1} = {P_k[14:0],1'b0} ^ (P_k[15] ? 16'h100B : 16'h0000).
  - `sa_reset_b`=0 for k<LATENCY and 1 for k≥LATENCY.
- DRAIN: LATENCY cycles.
  - `pat_valid`=0 and `pat_out`=0.
  - `sa_reset_b`=1 in every DRAIN cycle whose overall index k=N+d satisfies k≥LATENCY.
  - With this rule, response R_0 is compacted exactly at the edge ending RUN/DRAIN index LATENCY, starting from 16'hFFFF.
- CAPTURE: one cycle.
  - At the closing edge, `signature`<=`sa_out` and `pass`<=(`sa_out`==golden).
  - This is the cycle after R_{N-1} was compacted.
  - Go to IDLE with `done`=1 for that following cycle.
- N=0: the sequence is INIT → CAPTURE, skipping RUN and DRAIN. `sa_reset_b` stays 0 throughout, so the signature is 16'hFFFF.
- `abort` in any non-IDLE state:
  - Go to IDLE at the next edge.
  - `sa_reset_b`=0, `pat_valid`=0, no `done`.
  - `pass` and `signature` keep their cleared values.
- `start` and `abort` high together in IDLE: `abort` wins and `start` is ignored.
- `start` while `busy` is ignored and does not restart the run.
- `reset_b` low at any time immediately forces the reset values, including in mid-RUN.
- The pattern counter is CNT_W bits wide. N=2^CNT_W-1 must run without wrapping.

## Timing
- Take `start` sampled high in cycle 0.
  - INIT is cycle 1.
  - RUN is cycles 2..N+1.
  - DRAIN is cycles N+2..N+1+LATENCY.
  - CAPTURE is cycle N+2+LATENCY.
  - `done` is in cycle N+3+LATENCY, with `signature`/`pass` valid from the same cycle.
- For N=0: CAPTURE is cycle 2 and `done` is in cycle 3.
- `busy` falls in the `done` cycle. A new `start` is accepted in the `done` cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `reset_b` mid-RUN (N=100) → in the same cycle, all outputs take their reset values and `sa_reset_b`=0. After release, the block is in IDLE.
- Pattern sequence, with `seed`=16'h8000, N=3:
  - `pat_out` is 16'h8000, 16'h100B, 16'h2016 in cycles 2, 3, 4, with `pat_valid`=1 only then.
  - With `seed`=0, P_0 is 16'h0001.
- Signature alignment, with LATENCY=2, N=1 and the real analyzer fed constant response 16'h0000:
  - `sa_reset_b` rises in cycle 4.
  - `signature`=16'hEFF5, and `pass`=1 for `golden`=16'hEFF5.
  - `done` is in cycle 6.
- Zero patterns, N=0 with `golden`=16'hFFFF → `pass`=1, `signature`=16'hFFFF, `done` in cycle 3, and `pat_valid` never high.
- Abort, then restart:
  - `abort` in RUN cycle 5 of N=20 → IDLE next cycle, no `done`, `sa_reset_b`=0.
  - A following `start` completes normally.
  - `start`+`abort` together in IDLE is ignored.
- Busy lockout: pulse `start` in RUN of N=10 → the first run finishes at the original `done` cycle with its own golden.
